// File: rtl/clkmon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : clkmon_pkg                                                       |
// | Brief   : Shared types and sizing helpers for the divided-clock monitor.   |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
package clkmon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_t;

  localparam int DEF_CNT_W    = 8;
  localparam int DEF_LOCK_CNT = 4;
  localparam int GOOD_CNT_W   = $clog2(DEF_LOCK_CNT + 1);

  // Good-count width for an arbitrary LOCK_CNT override.
  function automatic int good_cnt_width(input int lock_cnt);
    return (lock_cnt < 1) ? 1 : $clog2(lock_cnt + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clkmon_edge_det.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : clkmon_edge_det                                                  |
// | Brief   : Samples div_clk as data, flags rising edges, registers a pulse.  |
// |           CLK_DIV_MONITOR_SYNC_EN adds a 2-flop input synchroniser.        |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module clkmon_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic div_clk_i,
  output logic rise_o,
  output logic edge_pulse_o
);

  logic div_d;
  logic div_q;
  logic edge_pulse_q;

`ifdef CLK_DIV_MONITOR_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], div_clk_i};
    end
  end

  assign div_d = sync_q[1];
`else
  assign div_d = div_clk_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q        <= 1'b0;
      edge_pulse_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      edge_pulse_q <= rise_o;
    end
  end

  assign rise_o       = div_d & ~div_q;
  assign edge_pulse_o = edge_pulse_q;

endmodule
`default_nettype wire

// File: rtl/clk_div_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : clk_div_monitor                                                  |
// | Brief   : Edge pulse, period measurement, lock and sticky fault for a      |
// |           divided clock sampled on clk. Option: CLK_DIV_MONITOR_SYNC_EN.   |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module clk_div_monitor
  import clkmon_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int EXP_PERIOD = 4,
  parameter int TOL        = 0,
  parameter int LOCK_CNT   = DEF_LOCK_CNT,
  parameter int TIMEOUT    = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             div_clk_i,
  input  logic             fault_clr_i,
  output logic             edge_pulse_o,
  output logic [CNT_W-1:0] period_o,
  output logic             locked_o,
  output logic             fault_o
);

  localparam int GW   = good_cnt_width(LOCK_CNT);
  localparam int LO_I = (EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0;
  localparam int HI_I = EXP_PERIOD + TOL;

  localparam logic [CNT_W:0]   GOOD_LO   = (CNT_W+1)'(LO_I);
  localparam logic [CNT_W:0]   GOOD_HI   = (CNT_W+1)'(HI_I);
  localparam logic [CNT_W-1:0] TMO_C     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [GW-1:0]    LOCK_C    = GW'(LOCK_CNT);
  localparam logic [GW-1:0]    GCNT_ONE  = GW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [GW-1:0]    good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             locked_q;
  logic             fault_q;

  logic             rise;
  logic             good;
  logic             timeout;
  logic [CNT_W:0]   per_cnt_ext;

  clkmon_edge_det u_edge_det (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .div_clk_i    (div_clk_i),
    .rise_o       (rise),
    .edge_pulse_o (edge_pulse_o)
  );

  assign per_cnt_ext = {1'b0, per_cnt_q};
  assign good        = (per_cnt_ext >= GOOD_LO) && (per_cnt_ext <= GOOD_HI);
  assign timeout     = (per_cnt_q == TMO_C) && !rise;

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    period_d   = period_q;
    if (rise) begin
      per_cnt_d = CNT_ONE;
    end else if (per_cnt_q == CNT_MAX) begin
      per_cnt_d = per_cnt_q;
    end else begin
      per_cnt_d = per_cnt_q + CNT_ONE;
    end

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d    = ACQUIRE;
          good_cnt_d = '0;
        end else if (timeout) begin
          state_d = FAULT;
        end
      end
      ACQUIRE: begin
        if (rise) begin
          period_d = per_cnt_q;
          if (good) begin
            good_cnt_d = good_cnt_q + GCNT_ONE;
            if (good_cnt_d == LOCK_C) begin
              state_d = LOCKED;
            end
          end else begin
            good_cnt_d = '0;
          end
        end else if (timeout) begin
          state_d = FAULT;
        end
      end
      LOCKED: begin
        if (rise) begin
          period_d = per_cnt_q;
          if (!good) begin
            state_d = FAULT;
          end
        end else if (timeout) begin
          state_d = FAULT;
        end
      end
      FAULT: begin
        // Clear wins over a coincident rise: acquisition restarts from zero.
        if (fault_clr_i) begin
          state_d    = IDLE;
          per_cnt_d  = '0;
          good_cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      per_cnt_q  <= '0;
      good_cnt_q <= '0;
      period_q   <= '0;
      locked_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      per_cnt_q  <= per_cnt_d;
      good_cnt_q <= good_cnt_d;
      period_q   <= period_d;
      locked_q   <= (state_d == LOCKED);
      fault_q    <= (state_d == FAULT);
    end
  end

  assign period_o = period_q;
  assign locked_o = locked_q;
  assign fault_o  = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_clk_div_monitor                                               |
// | Brief   : Scoreboard bench for clk_div_monitor (sync option off).          |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_clk_div_monitor;

  localparam int CNT_W      = 8;
  localparam int EXP_PERIOD = 4;
  localparam int TOL        = 0;
  localparam int LOCK_CNT   = 4;
  localparam int TIMEOUT    = 16;
  localparam int SAT        = (1 << CNT_W) - 1;

  localparam int M_IDLE = 0;
  localparam int M_ACQ  = 1;
  localparam int M_LCK  = 2;
  localparam int M_FLT  = 3;

  typedef struct {
    int         cyc;
    logic       e;
    logic [7:0] p;
    logic       l;
    logic       f;
  } exp_t;

  logic             clk;
  logic             rst_ni;
  logic             div_clk;
  logic             fault_clr;
  logic             edge_pulse;
  logic [CNT_W-1:0] period;
  logic             locked;
  logic             fault;

  exp_t exp_q[$];
  int   n_vec;
  int   n_err;

  int         m_cyc;
  int         m_ref;
  int         m_mode;
  int         m_streak;
  logic [7:0] m_period;
  bit         m_prev;

  clk_div_monitor #(
    .CNT_W      (CNT_W),
    .EXP_PERIOD (EXP_PERIOD),
    .TOL        (TOL),
    .LOCK_CNT   (LOCK_CNT),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .div_clk_i    (div_clk),
    .fault_clr_i  (fault_clr),
    .edge_pulse_o (edge_pulse),
    .period_o     (period),
    .locked_o     (locked),
    .fault_o      (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_cyc    = 0;
    m_ref    = 0;
    m_mode   = M_IDLE;
    m_streak = 0;
    m_period = 8'd0;
    m_prev   = 1'b0;
  endtask

  // Reference: elapsed = cycles since the last rise (or restart), judged by the lock/fault rules.
  task automatic model_step(input bit div, input bit clr, output exp_t ex);
    int  el;
    bit  rise;
    bit  good;
    bit  tmo;
    bit  cleared;
    el      = m_cyc - m_ref;
    if (el > SAT) el = SAT;
    rise    = div && !m_prev;
    good    = (el >= EXP_PERIOD - TOL) && (el <= EXP_PERIOD + TOL);
    tmo     = (el == TIMEOUT) && !rise;
    cleared = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (rise) begin m_mode = M_ACQ; m_streak = 0; end
        else if (tmo) m_mode = M_FLT;
      end
      M_ACQ: begin
        if (rise) begin
          m_period = el[7:0];
          if (good) begin
            m_streak++;
            if (m_streak == LOCK_CNT) m_mode = M_LCK;
          end else begin
            m_streak = 0;
          end
        end else if (tmo) m_mode = M_FLT;
      end
      M_LCK: begin
        if (rise) begin
          m_period = el[7:0];
          if (!good) m_mode = M_FLT;
        end else if (tmo) m_mode = M_FLT;
      end
      default: begin
        if (clr) begin m_mode = M_IDLE; m_streak = 0; cleared = 1'b1; end
      end
    endcase
    if (cleared)   m_ref = m_cyc + 1;
    else if (rise) m_ref = m_cyc;
    ex.cyc = m_cyc;
    ex.e   = rise;
    ex.p   = m_period;
    ex.l   = (m_mode == M_LCK);
    ex.f   = (m_mode == M_FLT);
    m_prev = div;
    m_cyc++;
  endtask

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic drive_cycle(input bit div, input bit clr);
    exp_t ex;
    div_clk   = div;
    fault_clr = clr;
    model_step(div, clr, ex);
    exp_q.push_back(ex);
    @(negedge clk);
  endtask

  task automatic drive_period(input int p, input int hi, input bit rnd_clr);
    for (int i = 0; i < p; i++) begin
      drive_cycle(i >= (p - hi), rnd_clr && ($urandom_range(0, 15) == 0));
    end
  endtask

  task automatic check_zero(input string tag);
    n_vec++;
    if (edge_pulse !== 1'b0 || period !== '0 || locked !== 1'b0 || fault !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got edge=%0b period=%0d locked=%0b fault=%0b, required all 0",
               tag, edge_pulse, period, locked, fault);
    end
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_ni = 1'b0;
    exp_q.delete();
    #1;
    check_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    div_clk   = 1'b0;
    fault_clr = 1'b0;
    rst_ni    = 1'b1;
    model_reset();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t ex;
        ex = exp_q.pop_front();
        n_vec++;
        if (edge_pulse !== ex.e || period !== ex.p || locked !== ex.l || fault !== ex.f) begin
          n_err++;
          $display("FAIL out cyc %0d: got edge=%0b period=%0d locked=%0b fault=%0b, exp edge=%0b period=%0d locked=%0b fault=%0b",
                   ex.cyc, edge_pulse, period, locked, fault, ex.e, ex.p, ex.l, ex.f);
        end
      end
    end
  end

  initial begin
    int r;
    int p;
    n_vec     = 0;
    n_err     = 0;
    rst_ni    = 1'b0;
    div_clk   = 1'b0;
    fault_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst_ni = 1'b1;

    repeat (8) drive_period(4, 2, 1'b0);        // acquire and lock
    drive_cycle(1'b0, 1'b1);                    // clear while locked: ignored
    drive_period(3, 2, 1'b0);
    repeat (4) drive_period(4, 2, 1'b0);
    repeat (20) drive_cycle(1'b0, 1'b0);        // stall -> timeout fault
    drive_cycle(1'b0, 1'b1);
    repeat (7) drive_period(4, 2, 1'b0);
    drive_period(5, 2, 1'b0);                   // bad period while locked
    repeat (3) drive_period(4, 2, 1'b0);
    drive_cycle(1'b0, 1'b1);
    drive_period(4, 2, 1'b0);
    drive_period(4, 2, 1'b0);
    drive_period(6, 2, 1'b0);                   // breaks the good streak
    repeat (5) drive_period(4, 2, 1'b0);
    drive_period(16, 2, 1'b0);                  // rise exactly at timeout
    drive_cycle(1'b0, 1'b1);
    repeat (6) drive_period(4, 2, 1'b0);
    async_reset();
    repeat (7) drive_period(4, 2, 1'b0);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      p = 4;
      else if (r < 8) p = (r == 6) ? 3 : 5;
      else            p = $urandom_range(2, 24);
      drive_period(p, $urandom_range(1, p - 1), 1'b1);
    end

    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
